// File: rtl/ex_forward_source.sv
// EX-stage producer for register forwarding: registers the EX result for bypass,
// sequences the multi-cycle mul/div that writes R0, and raises the ID-stage stall.
module ex_forward_source #(
    parameter int REG_NUM_WIDTH = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic [REG_NUM_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]    ex_result,
    input  logic                     ex_write_reg,
    input  logic                     ex_is_load,
    input  logic                     ex_muldiv_start,
    input  logic [DATA_WIDTH-1:0]    muldiv_result,
    input  logic [REG_NUM_WIDTH-1:0] id_rn_1,
    input  logic [REG_NUM_WIDTH-1:0] id_rn_2,
    input  logic                     id_is_muldiv,
    output logic [REG_NUM_WIDTH-1:0] rn1_ex,
    output logic                     write_reg,
    output logic [DATA_WIDTH-1:0]    fwd_data,
    output logic                     write_r0,
    output logic [DATA_WIDTH-1:0]    r0_data,
    output logic                     muldiv_busy,
    output logic                     stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(MULDIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic       capture;
    logic       ld_pending;
    logic       load_use;
    logic       r0_in_flight;
    logic       structural;

    // Pipeline register and FSM state; the pipeline register is never held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rn1_ex     <= '0;
            fwd_data   <= '0;
            write_reg  <= 1'b0;
            ld_pending <= 1'b0;
            r0_data    <= '0;
            state      <= IDLE;
            count      <= '0;
        end else begin
            rn1_ex     <= ex_rd;
            fwd_data   <= ex_result;
            write_reg  <= ex_valid & ex_write_reg & ~ex_is_load & ~ex_muldiv_start;
            ld_pending <= ex_valid & ex_write_reg & ex_is_load;
            state      <= state_nxt;
            count      <= count_nxt;
            if (capture) begin
                r0_data <= muldiv_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && ex_muldiv_start) begin
                    state_nxt = BUSY;
                    count_nxt = COUNT_INIT;
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // write_r0 decodes the state register, so it is a clean registered pulse.
    assign write_r0    = (state == DONE);
    assign muldiv_busy = (state == BUSY) || (state == DONE);

    // R0 readers are not stalled in DONE; they take r0_data on forward code 10.
    assign load_use     = ld_pending && ((id_rn_1 == rn1_ex) || (id_rn_2 == rn1_ex));
    assign r0_in_flight = (state == BUSY) && ((id_rn_1 == '0) || (id_rn_2 == '0));
    assign structural   = muldiv_busy && id_is_muldiv;
    assign stall        = load_use || r0_in_flight || structural;

endmodule

// File: tb/tb_ex_forward_source.sv
// Bench for ex_forward_source: directed vectors, an edge-count model of the
// forwarding/mul-div behaviour checked every cycle, plus literal spot checks.
module tb_ex_forward_source;

    localparam int RW = 4;
    localparam int DW = 16;
    localparam int MC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_result;
    logic          ex_write_reg;
    logic          ex_is_load;
    logic          ex_muldiv_start;
    logic [DW-1:0] muldiv_result;
    logic [RW-1:0] id_rn_1;
    logic [RW-1:0] id_rn_2;
    logic          id_is_muldiv;
    logic [RW-1:0] rn1_ex;
    logic          write_reg;
    logic [DW-1:0] fwd_data;
    logic          write_r0;
    logic [DW-1:0] r0_data;
    logic          muldiv_busy;
    logic          stall;

    int n_cmp = 0;
    int n_err = 0;

    ex_forward_source #(
        .REG_NUM_WIDTH(RW),
        .DATA_WIDTH   (DW),
        .MULDIV_CYCLES(MC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_result      (ex_result),
        .ex_write_reg   (ex_write_reg),
        .ex_is_load     (ex_is_load),
        .ex_muldiv_start(ex_muldiv_start),
        .muldiv_result  (muldiv_result),
        .id_rn_1        (id_rn_1),
        .id_rn_2        (id_rn_2),
        .id_is_muldiv   (id_is_muldiv),
        .rn1_ex         (rn1_ex),
        .write_reg      (write_reg),
        .fwd_data       (fwd_data),
        .write_r0       (write_r0),
        .r0_data        (r0_data),
        .muldiv_busy    (muldiv_busy),
        .stall          (stall)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Model: m_age counts edges since an accepted mul/div start (-1 = none).
    logic [RW-1:0] m_rn1;
    logic [DW-1:0] m_fwd;
    logic          m_wr;
    logic          m_ldp;
    logic [DW-1:0] m_r0;
    int            m_age;

    always @(posedge clk) begin
        if (rst) begin
            m_rn1 <= '0;
            m_fwd <= '0;
            m_wr  <= 1'b0;
            m_ldp <= 1'b0;
            m_r0  <= '0;
            m_age <= -1;
        end else begin
            m_rn1 <= ex_rd;
            m_fwd <= ex_result;
            m_wr  <= ex_valid && ex_write_reg && !ex_is_load && !ex_muldiv_start;
            m_ldp <= ex_valid && ex_write_reg && ex_is_load;
            if (m_age < 0) begin
                if (ex_valid && ex_muldiv_start) m_age <= 1;
            end else if (m_age >= MC + 1) begin
                m_age <= -1;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 == MC + 1) m_r0 <= muldiv_result;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic e_busy, e_wr0, e_inflight, e_stall;
        e_busy     = (m_age >= 1);
        e_wr0      = (m_age == MC + 1);
        e_inflight = (m_age >= 1) && (m_age <= MC);
        e_stall    = (m_ldp && ((id_rn_1 == m_rn1) || (id_rn_2 == m_rn1)))
                  || (e_inflight && ((id_rn_1 == '0) || (id_rn_2 == '0)))
                  || (e_busy && id_is_muldiv);
        check("rn1_ex", 32'(rn1_ex), 32'(m_rn1));
        check("write_reg", 32'(write_reg), 32'(m_wr));
        check("fwd_data", 32'(fwd_data), 32'(m_fwd));
        check("write_r0", 32'(write_r0), 32'(e_wr0));
        check("r0_data", 32'(r0_data), 32'(m_r0));
        check("muldiv_busy", 32'(muldiv_busy), 32'(e_busy));
        check("stall", 32'(stall), 32'(e_stall));
    endtask

    // Inputs are driven on the falling edge; outputs are checked one falling edge later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle_inputs();
        ex_valid        = 1'b0;
        ex_rd           = '0;
        ex_result       = '0;
        ex_write_reg    = 1'b0;
        ex_is_load      = 1'b0;
        ex_muldiv_start = 1'b0;
        muldiv_result   = 16'hDEAD;
        id_rn_1         = 4'hF;
        id_rn_2         = 4'hE;
        id_is_muldiv    = 1'b0;
    endtask

    task automatic drive_write(input logic [RW-1:0] rd, input logic [DW-1:0] data, input logic load);
        ex_valid     = 1'b1;
        ex_write_reg = 1'b1;
        ex_rd        = rd;
        ex_result    = data;
        ex_is_load   = load;
    endtask

    task automatic drive_start();
        idle_inputs();
        ex_valid        = 1'b1;
        ex_write_reg    = 1'b1;
        ex_muldiv_start = 1'b1;
        ex_rd           = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_rn1_ex", 32'(rn1_ex), 32'h0);
        check("rst_write_reg", 32'(write_reg), 32'h0);
        check("rst_fwd_data", 32'(fwd_data), 32'h0);
        check("rst_write_r0", 32'(write_r0), 32'h0);
        check("rst_r0_data", 32'(r0_data), 32'h0);
        check("rst_busy", 32'(muldiv_busy), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        tick();

        // Plain ALU write to r3
        drive_write(4'd3, 16'h1234, 1'b0);
        tick();
        check("t1_rn1_ex", 32'(rn1_ex), 32'h3);
        check("t1_write_reg", 32'(write_reg), 32'h1);
        check("t1_fwd_data", 32'(fwd_data), 32'h1234);
        check("t1_stall", 32'(stall), 32'h0);

        // Load-use on r5
        idle_inputs();
        drive_write(4'd5, 16'h7777, 1'b1);
        id_rn_2 = 4'd5;
        tick();
        check("t2_stall_hit", 32'(stall), 32'h1);
        check("t2_write_reg_load", 32'(write_reg), 32'h0);
        idle_inputs();
        drive_write(4'd5, 16'h7777, 1'b1);
        id_rn_1 = 4'd6;
        id_rn_2 = 4'd7;
        tick();
        check("t2_stall_miss", 32'(stall), 32'h0);
        check("t2_write_reg_miss", 32'(write_reg), 32'h0);
        idle_inputs();
        id_rn_1 = 4'd5;
        tick();
        check("t2_no_pending", 32'(stall), 32'h0);

        // Mul/div timing: BEEF presented only on the count-0 cycle
        drive_start();
        for (int i = 1; i <= MC + 1; i++) begin
            if (i == 2) idle_inputs();
            if (i == MC + 1) muldiv_result = 16'hBEEF;
            tick();
            check("t3_busy", 32'(muldiv_busy), 32'h1);
            check("t3_write_r0", 32'(write_r0), (i == MC + 1) ? 32'h1 : 32'h0);
            if (i == 1) check("t3_write_reg_start", 32'(write_reg), 32'h0);
        end
        check("t3_r0_data", 32'(r0_data), 32'hBEEF);
        muldiv_result = 16'hDEAD;
        tick();
        check("t3_write_r0_after", 32'(write_r0), 32'h0);
        check("t3_busy_after", 32'(muldiv_busy), 32'h0);
        check("t3_r0_hold", 32'(r0_data), 32'hBEEF);

        // Stall while BUSY, none for R0 readers in DONE
        drive_start();
        tick();
        idle_inputs();
        id_rn_1 = 4'd0;
        tick();
        check("t4_r0_busy_stall", 32'(stall), 32'h1);
        id_rn_1 = 4'hF;
        id_is_muldiv = 1'b1;
        tick();
        check("t4_struct_stall", 32'(stall), 32'h1);
        id_is_muldiv = 1'b0;
        id_rn_2 = 4'd9;
        tick();
        check("t4_no_stall", 32'(stall), 32'h0);
        id_rn_1 = 4'd0;
        muldiv_result = 16'h4321;
        tick();
        check("t4_done_wr0", 32'(write_r0), 32'h1);
        check("t4_done_no_stall", 32'(stall), 32'h0);
        idle_inputs();
        tick();

        // EX write to r0 coinciding with DONE; r0 write during BUSY also legal
        drive_start();
        tick();
        idle_inputs();
        drive_write(4'd0, 16'h00AA, 1'b0);
        tick();
        check("t6_busy_r0_write", 32'(write_reg), 32'h1);
        idle_inputs();
        tick();
        tick();
        drive_write(4'd0, 16'h0001, 1'b0);
        muldiv_result = 16'h5A5A;
        tick();
        check("t6_write_reg", 32'(write_reg), 32'h1);
        check("t6_rn1_ex", 32'(rn1_ex), 32'h0);
        check("t6_fwd_data", 32'(fwd_data), 32'h0001);
        check("t6_write_r0", 32'(write_r0), 32'h1);
        check("t6_r0_data", 32'(r0_data), 32'h5A5A);
        // A start presented during DONE is ignored
        drive_start();
        tick();
        check("t6_start_in_done", 32'(muldiv_busy), 32'h0);
        idle_inputs();
        tick();

        // Reset while BUSY with count 2
        drive_start();
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        check("t5_busy", 32'(muldiv_busy), 32'h0);
        check("t5_write_r0", 32'(write_r0), 32'h0);
        check("t5_r0_data", 32'(r0_data), 32'h0);
        check("t5_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_pulse", 32'(write_r0), 32'h0);
        end

        // Back-to-back writes to varied registers
        for (int i = 0; i < 6; i++) begin
            drive_write(RW'(i + 8), DW'(16'h1000 + i * 16'h0111), 1'b0);
            tick();
            check("seq_fwd", 32'(fwd_data), 32'(16'h1000 + i * 16'h0111));
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
